// File: rtl/gamepad_pkg.sv
// Shared definitions for the SNES controller front end.
// Button index map, button-bus width and the reader FSM state encoding.
// No logic; imported by the reader and by any consumer of the button bus.
package gamepad_pkg;

  localparam int N_BUTTONS = 12;

  // Serial bit k of the pad stream lands on button bus bit k.
  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    SETTLE = 3'd2,
    LOW    = 3'd3,
    HIGH   = 3'd4,
    DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Latency: 2 clocks from input to q_o.
// No backpressure; free-running.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops resolve metastability on the pad line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/snes_gamepad_reader.sv
// Once-per-frame SNES pad reader: latch, clock out serial stream, publish buttons + new presses.
// Latency: sample_valid rises (3+2*(SHIFT_BITS-1))*CLK_DIV+1 clocks after LATCH entry.
// No backpressure; v_sync edges arriving mid-read are dropped, not queued.
module snes_gamepad_reader #(
  parameter int CLK_DIV    = 300,
  parameter int SHIFT_BITS = 16,
  parameter int N_BUTTONS  = gamepad_pkg::N_BUTTONS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 v_sync,
  input  logic                 pad_data,
  output logic                 pad_latch,
  output logic                 pad_clk,
  output logic [N_BUTTONS-1:0] gamepad_input,
  output logic [N_BUTTONS-1:0] new_press,
  output logic                 sample_valid
);
  import gamepad_pkg::*;

  localparam int TMR_W = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam int IDX_W = (SHIFT_BITS > 1) ? $clog2(SHIFT_BITS) : 1;
  localparam logic [TMR_W-1:0] T_LATCH  = TMR_W'(2 * CLK_DIV - 1);
  localparam logic [TMR_W-1:0] T_PHASE  = TMR_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SHIFT_BITS - 1);

  state_e               state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [N_BUTTONS-1:0] shift_q, shift_d;
  logic                 v_sync_q;
  logic                 pad_latch_q, pad_latch_d;
  logic                 pad_clk_q, pad_clk_d;
  logic [N_BUTTONS-1:0] btn_q, press_q;
  logic                 valid_q;
  logic                 pad_sync;
  logic                 start;
  logic                 cap_vld;
  logic [IDX_W-1:0]     cap_idx;
  // A sample point is the pin value at the end of a phase. The synchronized copy of
  // that value appears two clocks later, so the bit index rides a 2-deep pipe to meet it.
  // Bits above N_BUTTONS are never stored, which keeps the pipe drained before DONE
  // as long as SHIFT_BITS > N_BUTTONS.
  logic                 pend1_vld_q, pend2_vld_q;
  logic [IDX_W-1:0]     pend1_idx_q, pend2_idx_q;

  sync_2ff u_pad_sync (
    .clk_i (clock),
    .rst_i (reset),
    .d_i   (pad_data),
    .q_o   (pad_sync)
  );

  assign start = (state_q == IDLE) && v_sync && !v_sync_q;

  // Sequencer: phase timing, bit index and sample points.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TMR_W'(1);
    idx_d   = idx_q;
    cap_vld = 1'b0;
    cap_idx = idx_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (start) state_d = LATCH;
      end
      LATCH: begin
        if (timer_q == T_LATCH) begin
          state_d = SETTLE;
          timer_d = '0;
        end
      end
      SETTLE: begin
        if (timer_q == T_PHASE) begin
          cap_vld = 1'b1;
          cap_idx = '0;
          idx_d   = IDX_W'(1);
          state_d = LOW;
          timer_d = '0;
        end
      end
      LOW: begin
        if (timer_q == T_PHASE) begin
          state_d = HIGH;
          timer_d = '0;
        end
      end
      HIGH: begin
        if (timer_q == T_PHASE) begin
          cap_vld = 1'b1;
          timer_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = LOW;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        timer_d = '0;
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Pad strobes registered from next state so they stay glitch-free and track state_q.
  always_comb begin
    pad_latch_d = (state_d == LATCH);
    pad_clk_d   = (state_d != LOW);
  end

  // Shift register: cleared at start, written with the inverted (active-high) bit.
  always_comb begin
    shift_d = shift_q;
    if (start) begin
      shift_d = '0;
    end else if (pend2_vld_q) begin
      for (int b = 0; b < N_BUTTONS; b++) begin
        if (int'(pend2_idx_q) == b) shift_d[b] = ~pad_sync;
      end
    end
  end

  // State, counters, sample pipe and published outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      v_sync_q    <= 1'b0;
      pad_latch_q <= 1'b0;
      pad_clk_q   <= 1'b1;
      btn_q       <= '0;
      press_q     <= '0;
      valid_q     <= 1'b0;
      pend1_vld_q <= 1'b0;
      pend1_idx_q <= '0;
      pend2_vld_q <= 1'b0;
      pend2_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      v_sync_q    <= v_sync;
      pad_latch_q <= pad_latch_d;
      pad_clk_q   <= pad_clk_d;
      pend1_vld_q <= cap_vld;
      pend1_idx_q <= cap_idx;
      pend2_vld_q <= pend1_vld_q;
      pend2_idx_q <= pend1_idx_q;
      valid_q     <= (state_q == DONE);
      if (state_q == DONE) begin
        btn_q   <= shift_q;
        press_q <= shift_q & ~btn_q;
      end
    end
  end

  assign pad_latch     = pad_latch_q;
  assign pad_clk       = pad_clk_q;
  assign gamepad_input = btn_q;
  assign new_press     = press_q;
  assign sample_valid  = valid_q;

endmodule
